// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the fault-tolerance error monitor: FSM state encoding and timestamp width.
package cv32e40p_ft_pkg;

  localparam int unsigned FT_TS_W = 32;

  typedef enum logic [1:0] {
    OK,
    DEGRADED,
    ALARM,
    CLEAR
  } ft_mon_state_e;

endpackage

// File: rtl/cv32e40p_ft_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module cv32e40p_ft_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_err_monitor.sv
// Error monitor for TMR voter flags: per-source/global saturating counters, sticky status, alarm FSM.
// Optional free-running cycle stamp of the first error: define CV32E40P_FT_TIMESTAMP_EN.
module cv32e40p_ft_err_monitor
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned NSRC   = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned TOT_W  = 10,
  parameter int unsigned THRESH = 16,
  localparam int unsigned SelW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [NSRC-1:0]     err_i,
  input  logic                clr_req_i,
  output logic                clr_ack_o,
  input  logic [SelW-1:0]     rd_sel_i,
  output logic [CNT_W-1:0]    rd_cnt_o,
  output logic [NSRC-1:0]     sticky_o,
  output logic [TOT_W-1:0]    total_o,
  output logic                alarm_o,
  output logic                irq_o,
  output logic [FT_TS_W-1:0]  first_ts_o
);

  logic [NSRC-1:0]  ev;
  logic             any_ev;
  logic             clr_req_q;
  logic             clr_acc;
  logic [CNT_W-1:0] cnt [NSRC];
  logic [TOT_W-1:0] total;
  logic [TOT_W-1:0] tot_upd;
  logic             thr_hit;
  logic [NSRC-1:0]  sticky_q, sticky_d;
  logic             irq_q, irq_d;
  ft_mon_state_e    state_q, state_d;

  assign ev      = enable_i ? err_i : '0;
  assign any_ev  = |ev;
  // Only a rising edge of the request is accepted; a held level does not retrigger.
  assign clr_acc = clr_req_i & ~clr_req_q;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    cv32e40p_ft_sat_cnt #(
      .W(CNT_W)
    ) u_src_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (ev[i]),
      .clr_i (clr_acc),
      .cnt_o (cnt[i])
    );
  end

  cv32e40p_ft_sat_cnt #(
    .W(TOT_W)
  ) u_tot_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (any_ev),
    .clr_i (clr_acc),
    .cnt_o (total)
  );

  // Value the total counter will hold after this edge, used for the threshold decision.
  assign tot_upd = (any_ev && (total != {TOT_W{1'b1}})) ? total + TOT_W'(1) : total;
  assign thr_hit = (tot_upd >= TOT_W'(THRESH));

  always_comb begin
    sticky_d = clr_acc ? '0 : (sticky_q | ev);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OK, CLEAR: begin
        if (any_ev) begin
          state_d = thr_hit ? ALARM : DEGRADED;
        end else begin
          state_d = OK;
        end
      end
      DEGRADED: begin
        if (thr_hit) begin
          state_d = ALARM;
        end
      end
      ALARM:   state_d = ALARM;
      default: state_d = OK;
    endcase
    if (clr_acc) begin
      state_d = CLEAR;
    end
    irq_d = (state_d == ALARM) && (state_q != ALARM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_req_q <= 1'b0;
      sticky_q  <= '0;
      irq_q     <= 1'b0;
      state_q   <= OK;
    end else begin
      clr_req_q <= clr_req_i;
      sticky_q  <= sticky_d;
      irq_q     <= irq_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    rd_cnt_o = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (rd_sel_i == SelW'(i)) begin
        rd_cnt_o = cnt[i];
      end
    end
  end

  assign sticky_o  = sticky_q;
  assign total_o   = total;
  assign alarm_o   = (state_q == ALARM);
  assign clr_ack_o = (state_q == CLEAR);
  assign irq_o     = irq_q;

`ifdef CV32E40P_FT_TIMESTAMP_EN
  logic [FT_TS_W-1:0] cyc_q;
  logic [FT_TS_W-1:0] ts_q;
  logic               ts_vld_q;

  // Cycle counter is free-running and deliberately unaffected by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q    <= '0;
      ts_q     <= '0;
      ts_vld_q <= 1'b0;
    end else begin
      cyc_q <= cyc_q + FT_TS_W'(1);
      if (clr_acc) begin
        ts_q     <= '0;
        ts_vld_q <= 1'b0;
      end else if (any_ev && !ts_vld_q) begin
        ts_q     <= cyc_q;
        ts_vld_q <= 1'b1;
      end
    end
  end

  assign first_ts_o = ts_q;
`else
  assign first_ts_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_ft_err_monitor.sv
// Directed bench for cv32e40p_ft_err_monitor; four configurations share one stimulus stream.
module tb_cv32e40p_ft_err_monitor;

`ifdef CV32E40P_FT_TIMESTAMP_EN
  localparam int unsigned ExpTs = 100;
`else
  localparam int unsigned ExpTs = 0;
`endif

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] err;
  logic       clr_req;
  logic [1:0] rd_sel;

  // Default configuration (THRESH=16)
  logic        d_ack, d_alarm, d_irq;
  logic [7:0]  d_rd;
  logic [3:0]  d_sticky;
  logic [9:0]  d_total;
  logic [31:0] d_ts;
  // THRESH=4
  logic        a_ack, a_alarm, a_irq;
  logic [7:0]  a_rd;
  logic [3:0]  a_sticky;
  logic [9:0]  a_total;
  logic [31:0] a_ts;
  // CNT_W=4, TOT_W=5
  logic        s_ack, s_alarm, s_irq;
  logic [3:0]  s_rd;
  logic [3:0]  s_sticky;
  logic [4:0]  s_total;
  logic [31:0] s_ts;
  // THRESH=1
  logic        o_ack, o_alarm, o_irq;
  logic [7:0]  o_rd;
  logic [3:0]  o_sticky;
  logic [9:0]  o_total;
  logic [31:0] o_ts;

  int n_total;
  int n_bad;

  cv32e40p_ft_err_monitor u_dut (
    .clk(clk), .rst(rst), .enable_i(enable), .err_i(err), .clr_req_i(clr_req),
    .clr_ack_o(d_ack), .rd_sel_i(rd_sel), .rd_cnt_o(d_rd), .sticky_o(d_sticky),
    .total_o(d_total), .alarm_o(d_alarm), .irq_o(d_irq), .first_ts_o(d_ts)
  );

  cv32e40p_ft_err_monitor #(.THRESH(4)) u_th4 (
    .clk(clk), .rst(rst), .enable_i(enable), .err_i(err), .clr_req_i(clr_req),
    .clr_ack_o(a_ack), .rd_sel_i(rd_sel), .rd_cnt_o(a_rd), .sticky_o(a_sticky),
    .total_o(a_total), .alarm_o(a_alarm), .irq_o(a_irq), .first_ts_o(a_ts)
  );

  cv32e40p_ft_err_monitor #(.CNT_W(4), .TOT_W(5)) u_sat (
    .clk(clk), .rst(rst), .enable_i(enable), .err_i(err), .clr_req_i(clr_req),
    .clr_ack_o(s_ack), .rd_sel_i(rd_sel), .rd_cnt_o(s_rd), .sticky_o(s_sticky),
    .total_o(s_total), .alarm_o(s_alarm), .irq_o(s_irq), .first_ts_o(s_ts)
  );

  cv32e40p_ft_err_monitor #(.THRESH(1)) u_th1 (
    .clk(clk), .rst(rst), .enable_i(enable), .err_i(err), .clr_req_i(clr_req),
    .clr_ack_o(o_ack), .rd_sel_i(rd_sel), .rd_cnt_o(o_rd), .sticky_o(o_sticky),
    .total_o(o_total), .alarm_o(o_alarm), .irq_o(o_irq), .first_ts_o(o_ts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    enable  = 1'b0;
    err     = 4'b0000;
    clr_req = 1'b0;
    rd_sel  = 2'd0;

    // Reset state
    #12;
    check_val("rst_sticky", 32'(d_sticky), 0);
    check_val("rst_total", 32'(d_total), 0);
    check_val("rst_alarm", 32'(d_alarm), 0);
    check_val("rst_irq", 32'(d_irq), 0);
    check_val("rst_ack", 32'(d_ack), 0);
    check_val("rst_rd", 32'(d_rd), 0);
    check_val("rst_ts", d_ts, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Drive THRESH=4 instance into ALARM, then assert reset with no clock edge
    enable = 1'b1;
    err    = 4'b0011;
    repeat (4) tick();
    enable = 1'b0;
    err    = 4'b0000;
    check_val("pre_rst_alarm", 32'(a_alarm), 1);
    check_val("pre_rst_total", 32'(a_total), 4);
    #2 rst = 1'b1;
    #1;
    check_val("async_alarm", 32'(a_alarm), 0);
    check_val("async_irq", 32'(a_irq), 0);
    check_val("async_total", 32'(a_total), 0);
    check_val("async_sticky", 32'(a_sticky), 0);
    check_val("async_rd", 32'(a_rd), 0);
    check_val("async_ts", a_ts, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check_val("post_rst_alarm", 32'(a_alarm), 0);
    check_val("post_rst_ack", 32'(a_ack), 0);
    repeat (99) tick();

    // Single error on source 2 at cycle 100 after reset release
    enable = 1'b1;
    err    = 4'b0100;
    rd_sel = 2'd2;
    tick();
    err = 4'b0000;
    check_val("t2_sticky", 32'(d_sticky), 32'h4);
    check_val("t2_rd2", 32'(d_rd), 1);
    check_val("t2_total", 32'(d_total), 1);
    check_val("t2_alarm", 32'(d_alarm), 0);
    check_val("t2_ts", d_ts, ExpTs);
    check_val("th1_alarm", 32'(o_alarm), 1);
    check_val("th1_irq", 32'(o_irq), 1);
    tick();
    check_val("th1_irq_once", 32'(o_irq), 0);
    check_val("th1_alarm_hold", 32'(o_alarm), 1);

    err = 4'b0001;
    tick();
    err = 4'b0000;
    check_val("t2_ts_keep", d_ts, ExpTs);
    check_val("t2_sticky2", 32'(d_sticky), 32'h5);
    check_val("t2_total2", 32'(d_total), 2);

    enable = 1'b0;
    err    = 4'b1111;
    tick();
    err = 4'b0000;
    check_val("dis_sticky", 32'(d_sticky), 32'h5);
    check_val("dis_total", 32'(d_total), 2);
    check_val("dis_rd2", 32'(d_rd), 1);

    // THRESH=4 alarm after the 4th event cycle
    do_clear();
    check_val("clr_total", 32'(a_total), 0);
    enable = 1'b1;
    err    = 4'b0011;
    rd_sel = 2'd0;
    repeat (3) tick();
    check_val("t3_alarm_3", 32'(a_alarm), 0);
    tick();
    err = 4'b0000;
    check_val("t3_alarm", 32'(a_alarm), 1);
    check_val("t3_irq", 32'(a_irq), 1);
    check_val("t3_total", 32'(a_total), 4);
    check_val("t3_cnt0", 32'(a_rd), 4);
    rd_sel = 2'd1;
    #1;
    check_val("t3_cnt1", 32'(a_rd), 4);
    tick();
    check_val("t3_irq_once", 32'(a_irq), 0);
    check_val("t3_alarm_hold", 32'(a_alarm), 1);

    // Saturation with CNT_W=4, TOT_W=5
    do_clear();
    err = 4'b0010;
    repeat (40) tick();
    err = 4'b0000;
    check_val("t4_cnt1_sat", 32'(s_rd), 15);
    check_val("t4_total_sat", 32'(s_total), 31);
    check_val("t4_sticky", 32'(s_sticky), 32'h2);
    check_val("t4_dut_cnt1", 32'(d_rd), 40);

    // Clear held high; event on accept edge discarded, event in CLEAR counted
    rd_sel  = 2'd3;
    err     = 4'b1000;
    clr_req = 1'b1;
    tick();
    check_val("t5_ack", 32'(d_ack), 1);
    check_val("t5_total0", 32'(d_total), 0);
    check_val("t5_sticky0", 32'(d_sticky), 0);
    check_val("t5_cnt3_0", 32'(d_rd), 0);
    check_val("t5_alarm0", 32'(d_alarm), 0);
    tick();
    err = 4'b0000;
    check_val("t5_ack_once", 32'(d_ack), 0);
    check_val("t5_cnt3_1", 32'(d_rd), 1);
    check_val("t5_total1", 32'(d_total), 1);
    check_val("t5_th1_alarm", 32'(o_alarm), 1);
    check_val("t5_th1_irq", 32'(o_irq), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t5_no_reack", 32'(d_ack), 0);
    end
    clr_req = 1'b0;
    tick();
    check_val("t5_cnt3_keep", 32'(d_rd), 1);
    check_val("t5_sticky", 32'(d_sticky), 32'h8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
